// File: rtl/alu_divider_if.sv
// Handshake and result bundle for the iterative divider: the requester drives
// operands and control, the divider returns status and the held results.
interface alu_divider_if #(
    parameter int N = 32
) ();
    logic         start;
    logic         sign;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, sign, a, b, cancel,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, sign, a, b, cancel,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider (DIV/DIVU): one quotient bit per clock on magnitudes,
// a final sign-fixup edge, and a single-cycle shortcut for a zero divisor.
module alu_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_divider_if.slave div_if
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  prem_q, prem_d;
    logic          neg_quot_q, neg_quot_d;
    logic          neg_rem_q, neg_rem_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  remd_q, remd_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic [N-1:0]  abs_a;
    logic [N-1:0]  abs_b;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        a_d        = a_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        quot_d     = quot_q;
        remd_d     = remd_q;
        dbz_d      = dbz_q;

        abs_a   = (div_if.sign && div_if.a[N-1]) ? -div_if.a : div_if.a;
        abs_b   = (div_if.sign && div_if.b[N-1]) ? -div_if.b : div_if.b;
        // Dividend bits leave dvd_q from the top while quotient bits enter at the bottom.
        shifted = {prem_q, dvd_q[N-1]};
        diff    = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (div_if.start && !div_if.cancel) begin
                    state_d    = RUN;
                    count_d    = '0;
                    a_d        = div_if.a;
                    dvd_d      = abs_a;
                    dvs_d      = abs_b;
                    prem_d     = '0;
                    neg_quot_d = div_if.sign && (div_if.a[N-1] != div_if.b[N-1]);
                    neg_rem_d  = div_if.sign && div_if.a[N-1];
                    zero_d     = (div_if.b == '0);
                end
            end
            RUN: begin
                if (div_if.cancel) begin
                    state_d = IDLE;
                end else if (zero_q) begin
                    state_d = DONE;
                    quot_d  = '1;
                    remd_d  = a_q;
                    dbz_d   = 1'b1;
                end else if (count_q == CW'(N)) begin
                    state_d = DONE;
                    quot_d  = neg_quot_q ? -dvd_q : dvd_q;
                    remd_d  = neg_rem_q ? -prem_q : prem_q;
                    dbz_d   = 1'b0;
                end else begin
                    count_d = count_q + CW'(1);
                    if (diff[N]) begin
                        prem_d = shifted[N-1:0];
                        dvd_d  = {dvd_q[N-2:0], 1'b0};
                    end else begin
                        prem_d = diff[N-1:0];
                        dvd_d  = {dvd_q[N-2:0], 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The zero-divisor pass still spends one cycle in RUN but is never reported busy.
        busy_d = (state_d == RUN) && !zero_d;
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            a_q        <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            a_q        <= a_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            quot_q     <= quot_d;
            remd_q     <= remd_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.quotient    = quot_q;
    assign div_if.remainder   = remd_q;
    assign div_if.div_by_zero = dbz_q;
endmodule
